// File: rtl/ram_arb_pkg.sv
// Shared types and helpers for the DDR2 local-interface arbiter.
package ram_arb_pkg;

    typedef enum logic [1:0] {IDLE, WR_BURST, RD_CMD} state_t;
    typedef enum logic {GNT_WR, GNT_RD} grant_t;

    localparam int SZ_MAX_W = 8;

    // A burst size of 0 is treated as a single beat.
    function automatic logic [SZ_MAX_W-1:0] eff_size(input logic [SZ_MAX_W-1:0] s);
        return (s == '0) ? SZ_MAX_W'(1) : s;
    endfunction

endpackage

// File: rtl/ram_arb_rd_tracker.sv
// Outstanding read-beat counter: admits a read only if its beats fit under
// MAX_RD_OUT, adds accepted bursts and retires returned beats in one update.
module ram_arb_rd_tracker #(
    parameter int SIZE_W     = 3,
    parameter int MAX_RD_OUT = 16,
    parameter int CW         = $clog2(MAX_RD_OUT + 8)
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              req_i,
    input  logic [SIZE_W-1:0] size_i,
    input  logic              inc_i,
    input  logic              dec_i,
    output logic              eligible_o
);

    localparam logic [CW:0] MAXW = (CW+1)'(MAX_RD_OUT);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          dec_ok;

    assign eligible_o = req_i && (({1'b0, cnt_q} + (CW+1)'(size_i)) <= MAXW);

    // A stray return beat at zero is dropped rather than wrapping.
    assign dec_ok = dec_i && (inc_i || cnt_q != '0);

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i)  cnt_d = cnt_d + CW'(size_i);
        if (dec_ok) cnt_d = cnt_d - CW'(1);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            assert (!(dec_i && !inc_i && cnt_q == '0));
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ram_local_arbiter.sv
// Two-client arbiter (write-only DAQ, read-only readout) for the DDR2 local
// interface. Optional performance counters: define RAM_ARB_PERF_CNT_EN.
module ram_local_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W     = 25,
    parameter int DATA_W     = 32,
    parameter int BE_W       = 4,
    parameter int SIZE_W     = 3,
    parameter int MAX_RD_OUT = 16
) (
    input  logic              phy_clk,
    input  logic              reset,
    input  logic              local_init_done,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [SIZE_W-1:0] wr_size,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [BE_W-1:0]   wr_be,
    output logic              wr_ready,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [SIZE_W-1:0] rd_size,
    output logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [ADDR_W-1:0] local_address,
    output logic [SIZE_W-1:0] local_size,
    output logic [DATA_W-1:0] local_wdata,
    output logic [BE_W-1:0]   local_be,
    output logic              local_burstbegin,
    output logic              local_write_req,
    output logic              local_read_req,
    input  logic              local_ready,
    input  logic [DATA_W-1:0] local_rdata,
    input  logic              local_rdata_valid,
    output logic [31:0]       perf_wr_beats,
    output logic [31:0]       perf_rd_beats,
    output logic [31:0]       perf_stall_cycles
);

    state_t            state_q, state_d;
    grant_t            last_q, last_d;
    logic [SIZE_W-1:0] beats_q, beats_d;
    logic              first_q, first_d;
    logic [SIZE_W-1:0] wr_eff, rd_eff;
    logic              rd_elig, rd_inc;

    assign wr_eff = SIZE_W'(eff_size(SZ_MAX_W'(wr_size)));
    assign rd_eff = SIZE_W'(eff_size(SZ_MAX_W'(rd_size)));

    assign rd_data  = local_rdata;
    assign rd_valid = local_rdata_valid;

    ram_arb_rd_tracker #(
        .SIZE_W     (SIZE_W),
        .MAX_RD_OUT (MAX_RD_OUT)
    ) u_trk (
        .clk_i      (phy_clk),
        .reset_i    (reset),
        .req_i      (rd_req),
        .size_i     (rd_eff),
        .inc_i      (rd_inc),
        .dec_i      (local_rdata_valid),
        .eligible_o (rd_elig)
    );

    always_comb begin
        state_d          = state_q;
        last_d           = last_q;
        beats_d          = beats_q;
        first_d          = first_q;
        local_address    = '0;
        local_size       = '0;
        local_wdata      = '0;
        local_be         = '0;
        local_burstbegin = 1'b0;
        local_write_req  = 1'b0;
        local_read_req   = 1'b0;
        wr_ready         = 1'b0;
        rd_ready         = 1'b0;
        rd_inc           = 1'b0;
        case (state_q)
            IDLE: begin
                if (local_init_done) begin
                    // On a tie the port that did not win last time goes first.
                    if (wr_req && (!rd_elig || last_q == GNT_RD)) begin
                        state_d = WR_BURST;
                        last_d  = GNT_WR;
                        beats_d = wr_eff;
                        first_d = 1'b1;
                    end else if (rd_elig) begin
                        state_d = RD_CMD;
                        last_d  = GNT_RD;
                    end
                end
            end
            WR_BURST: begin
                local_write_req  = wr_req;
                local_address    = wr_addr;
                local_size       = wr_size;
                local_wdata      = wr_data;
                local_be         = wr_be;
                local_burstbegin = first_q && wr_req;
                wr_ready         = wr_req && local_ready;
                if (wr_ready) begin
                    first_d = 1'b0;
                    beats_d = beats_q - SIZE_W'(1);
                    if (beats_q == SIZE_W'(1)) state_d = IDLE;
                end
            end
            RD_CMD: begin
                local_read_req   = 1'b1;
                local_burstbegin = 1'b1;
                local_address    = rd_addr;
                local_size       = rd_size;
                rd_ready         = local_ready;
                if (local_ready) begin
                    rd_inc  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge phy_clk) begin
        if (reset) begin
            state_q <= IDLE;
            last_q  <= GNT_RD;
            beats_q <= '0;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            beats_q <= beats_d;
            first_q <= first_d;
        end
    end

`ifdef RAM_ARB_PERF_CNT_EN
    logic [31:0] pwr_q, prd_q, pst_q;

    always_ff @(posedge phy_clk) begin
        if (reset) begin
            pwr_q <= '0;
            prd_q <= '0;
            pst_q <= '0;
        end else begin
            if (wr_ready)          pwr_q <= pwr_q + 32'd1;
            if (local_rdata_valid) prd_q <= prd_q + 32'd1;
            if ((local_write_req || local_read_req) && !local_ready)
                pst_q <= pst_q + 32'd1;
        end
    end

    assign perf_wr_beats     = pwr_q;
    assign perf_rd_beats     = prd_q;
    assign perf_stall_cycles = pst_q;
`else
    assign perf_wr_beats     = '0;
    assign perf_rd_beats     = '0;
    assign perf_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_ram_local_arbiter.sv
// Directed bench for ram_local_arbiter: init gating, write bursts, fair
// alternation, read-credit limiting, net counter update and perf counters.
module tb_ram_local_arbiter;
    import ram_arb_pkg::*;

    logic        phy_clk = 1'b0;
    logic        reset, local_init_done;
    logic        wr_req, rd_req, wr_ready, rd_ready, rd_valid;
    logic [24:0] wr_addr, rd_addr, local_address;
    logic [2:0]  wr_size, rd_size, local_size;
    logic [31:0] wr_data, rd_data, local_wdata, local_rdata;
    logic [3:0]  wr_be, local_be;
    logic        local_burstbegin, local_write_req, local_read_req;
    logic        local_ready, local_rdata_valid;
    logic [31:0] perf_wr_beats, perf_rd_beats, perf_stall_cycles;

    int n_cmp = 0;
    int n_err = 0;

    always #5 phy_clk = ~phy_clk;

    ram_local_arbiter dut (
        .phy_clk(phy_clk), .reset(reset), .local_init_done(local_init_done),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_size(wr_size), .wr_data(wr_data),
        .wr_be(wr_be), .wr_ready(wr_ready), .rd_req(rd_req), .rd_addr(rd_addr),
        .rd_size(rd_size), .rd_ready(rd_ready), .rd_data(rd_data), .rd_valid(rd_valid),
        .local_address(local_address), .local_size(local_size),
        .local_wdata(local_wdata), .local_be(local_be),
        .local_burstbegin(local_burstbegin), .local_write_req(local_write_req),
        .local_read_req(local_read_req), .local_ready(local_ready),
        .local_rdata(local_rdata), .local_rdata_valid(local_rdata_valid),
        .perf_wr_beats(perf_wr_beats), .perf_rd_beats(perf_rd_beats),
        .perf_stall_cycles(perf_stall_cycles)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge phy_clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        int acc, bb, rdy;
        state_t exp_alt [11];
        exp_alt = '{IDLE, WR_BURST, WR_BURST, IDLE, RD_CMD, IDLE,
                    WR_BURST, WR_BURST, IDLE, RD_CMD, IDLE};

        reset = 1'b1; local_init_done = 1'b0;
        wr_req = 1'b1; wr_addr = 25'h100; wr_size = 3'd4; wr_data = '0; wr_be = 4'hF;
        rd_req = 1'b0; rd_addr = 25'h200; rd_size = 3'd4;
        local_ready = 1'b0; local_rdata = '0; local_rdata_valid = 1'b0;
        tick(); tick();
        #1;
        chk("rst_state", 32'(dut.state_q), 32'(IDLE));
        chk("rst_wreq", 32'(local_write_req), 32'd0);
        chk("rst_wrdy", 32'(wr_ready), 32'd0);
        chk("rst_addr", 32'(local_address), 32'd0);
        chk("rst_out", 32'(dut.u_trk.cnt_q), 32'd0);

        // Init gating
        reset = 1'b0;
        tick(); tick();
        chk("noinit_state", 32'(dut.state_q), 32'(IDLE));
        chk("noinit_wreq", 32'(local_write_req), 32'd0);
        local_init_done = 1'b1;
        #1;
        chk("init_same_cyc", 32'(dut.state_q), 32'(IDLE));
        tick();
        chk("init_wr_grant", 32'(dut.state_q), 32'(WR_BURST));

        // 4-beat write, beat 2 stalled 3 cycles
        acc = 0; bb = 0;
        for (int c = 0; c < 7; c++) begin
            local_ready = !(c >= 1 && c <= 3);
            wr_data = 32'hD000 + c;
            #1;
            if (c == 0) begin
                chk("wr_addr", 32'(local_address), 32'h100);
                chk("wr_size", 32'(local_size), 32'd4);
                chk("wr_wdata", local_wdata, 32'hD000);
            end
            if (wr_ready) acc++;
            if (local_burstbegin) bb++;
            tick();
        end
        wr_req = 1'b0;
        #1;
        chk("wr_beats", 32'(acc), 32'd4);
        chk("wr_bb_cycles", 32'(bb), 32'd1);
        chk("wr_end_idle", 32'(dut.state_q), 32'(IDLE));

        // Alternation from reset, both ports requesting size 2
        do_reset();
        wr_req = 1'b1; wr_size = 3'd2; rd_req = 1'b1; rd_size = 3'd2; local_ready = 1'b1;
        for (int c = 0; c < 11; c++) begin
            #1;
            chk($sformatf("alt_c%0d", c), 32'(dut.state_q), 32'(exp_alt[c]));
            tick();
        end
        wr_req = 1'b0; rd_req = 1'b0;

        // Read credit limit: four 4-beat reads fill MAX_RD_OUT=16
        do_reset();
        rd_req = 1'b1; rd_size = 3'd4;
        rdy = 0;
        for (int c = 0; c < 14; c++) begin
            #1;
            if (rd_ready) rdy++;
            tick();
        end
        chk("rd_accepts", 32'(rdy), 32'd4);
        chk("rd_out16", 32'(dut.u_trk.cnt_q), 32'd16);
        chk("rd_blocked", 32'(dut.state_q), 32'(IDLE));
        local_rdata = 32'hCAFE0001; local_rdata_valid = 1'b1;
        #1;
        chk("rd_pass_data", rd_data, 32'hCAFE0001);
        chk("rd_pass_vld", 32'(rd_valid), 32'd1);
        tick(); tick(); tick();
        local_rdata_valid = 1'b0;
        #1;
        chk("rd_out13", 32'(dut.u_trk.cnt_q), 32'd13);
        tick();
        chk("rd_still_blk", 32'(dut.state_q), 32'(IDLE));
        local_rdata_valid = 1'b1;
        tick();
        local_rdata_valid = 1'b0;
        chk("rd_out12", 32'(dut.u_trk.cnt_q), 32'd12);
        chk("rd_idle_at12", 32'(dut.state_q), 32'(IDLE));
        tick();
        chk("rd_5th_grant", 32'(dut.state_q), 32'(RD_CMD));
        chk("rd_5th_rdy", 32'(rd_ready), 32'd1);
        tick();
        rd_req = 1'b0;
        chk("rd_out16b", 32'(dut.u_trk.cnt_q), 32'd16);

        // Same-cycle +4 / -1 from 10
        local_rdata_valid = 1'b1;
        for (int c = 0; c < 6; c++) tick();
        local_rdata_valid = 1'b0;
        chk("net_out10", 32'(dut.u_trk.cnt_q), 32'd10);
        rd_req = 1'b1;
        tick();
        chk("net_grant", 32'(dut.state_q), 32'(RD_CMD));
        local_rdata_valid = 1'b1;
        tick();
        local_rdata_valid = 1'b0; rd_req = 1'b0;
        chk("net_out13", 32'(dut.u_trk.cnt_q), 32'd13);

        // Perf counters: 3-beat write with 2 stall cycles
        do_reset();
        wr_req = 1'b1; wr_size = 3'd3; local_ready = 1'b0;
        tick();
        for (int c = 0; c < 5; c++) begin
            local_ready = (c == 0 || c >= 3);
            tick();
        end
        wr_req = 1'b0;
        #1;
        chk("perf_end_idle", 32'(dut.state_q), 32'(IDLE));
`ifdef RAM_ARB_PERF_CNT_EN
        chk("perf_wr", perf_wr_beats, 32'd3);
        chk("perf_stall", perf_stall_cycles, 32'd2);
        chk("perf_rd", perf_rd_beats, 32'd0);
`else
        chk("perf_wr", perf_wr_beats, 32'd0);
        chk("perf_stall", perf_stall_cycles, 32'd0);
        chk("perf_rd", perf_rd_beats, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
